// File: rtl/mem_moc_responder.sv
// Memory-side responder for the MOV/MOC handshake: big-endian byte-addressed RAM
// with programmable wait states, byte/halfword/word access and fault reporting.
module mem_moc_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mov,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        moc,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rw_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   dout_q;
    logic          err_q;
    logic [7:0]    mem_q [DEPTH];

    logic          accept;
    logic          commit;
    logic          fault;
    logic [AW-1:0] i0, i1, i2, i3;
    logic [31:0]   rdata;

    function automatic logic [2:0] nbytes(input logic [1:0] s);
        case (s)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Full 32-bit address (plus carry) goes into the range check, so high bits fault.
    function automatic logic access_fault(input logic [1:0] s, input logic [31:0] a);
        logic [32:0] end_addr;
        end_addr = {1'b0, a} + {30'b0, nbytes(s)};
        return (s == 2'b11)
            || (s == 2'b01 && a[0])
            || (s == 2'b10 && a[1:0] != 2'b00)
            || (end_addr > 33'(DEPTH));
    endfunction

    assign accept = !reset && state_q == IDLE && mov;
    assign commit = !reset && state_q == BUSY && mov && cnt_q == 4'd0;
    assign fault  = access_fault(size_q, addr_q);

    assign i0 = addr_q[AW-1:0];
    assign i1 = i0 + AW'(1);
    assign i2 = i0 + AW'(2);
    assign i3 = i0 + AW'(3);

    always_comb begin
        rdata = '0;
        case (size_q)
            2'b00:   rdata = {24'b0, mem_q[i0]};
            2'b01:   rdata = {16'b0, mem_q[i0], mem_q[i1]};
            2'b10:   rdata = {mem_q[i0], mem_q[i1], mem_q[i2], mem_q[i3]};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mov) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY);
                end
            end
            BUSY: begin
                if (!mov) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!mov) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        moc      = (state_q == ACK);
        err      = moc && err_q;
        data_out = dout_q;
    end

    // Request fields are frozen at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q    <= rw;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            err_q  <= 1'b0;
        end else if (commit) begin
            err_q  <= fault;
            dout_q <= (fault || !rw_q) ? 32'd0 : rdata;
        end
    end

    // Single commit cycle per request guarantees exactly one write.
    always_ff @(posedge clk) begin
        if (commit && !fault && !rw_q) begin
            case (size_q)
                2'b00: mem_q[i0] <= wdata_q[7:0];
                2'b01: begin
                    mem_q[i0] <= wdata_q[15:8];
                    mem_q[i1] <= wdata_q[7:0];
                end
                2'b10: begin
                    mem_q[i0] <= wdata_q[31:24];
                    mem_q[i1] <= wdata_q[23:16];
                    mem_q[i2] <= wdata_q[15:8];
                    mem_q[i3] <= wdata_q[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_moc_responder.sv
// Bench for mem_moc_responder: cycle-level reference model plus directed
// transactions with hand-computed results; a second instance covers LATENCY=0.
`timescale 1ns/1ps
module tb_mem_moc_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mov, rw;
    logic [1:0]  size;
    logic [31:0] addr, data_in;
    logic [31:0] data_out;
    logic        moc, err;

    logic        mov0, rw0;
    logic [1:0]  size0;
    logic [31:0] addr0, data_in0;
    logic [31:0] data_out0;
    logic        moc0, err0;

    int total = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_moc_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mov(mov), .rw(rw), .size(size), .addr(addr),
        .data_in(data_in), .data_out(data_out), .moc(moc), .err(err)
    );

    mem_moc_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .mov(mov0), .rw(rw0), .size(size0), .addr(addr0),
        .data_in(data_in0), .data_out(data_out0), .moc(moc0), .err(err0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: request lifetime tracked as phase + remaining wait cycles.
    logic [7:0]  m_mem [DEPTH];
    int          m_phase;
    int          m_wait;
    logic        m_rw;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_data;
    logic        exp_moc = 1'b0, exp_err = 1'b0, exp_dvalid = 1'b0;
    logic [31:0] exp_dout = 32'd0;

    initial begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 8'h00;
        m_phase = 0;
        m_wait  = 0;
    end

    task automatic model_access();
        int  nb;
        bit  bad;
        logic [31:0] v;
        nb = (m_size == 2'd0) ? 1 : (m_size == 2'd1) ? 2 : (m_size == 2'd2) ? 4 : 0;
        bad = (nb == 0);
        if (!bad) bad = ((m_addr % nb) != 0) || (longint'(m_addr) + nb > DEPTH);
        exp_err    = bad;
        exp_dvalid = bad || m_rw;
        exp_dout   = 32'd0;
        if (!bad) begin
            if (m_rw) begin
                v = 32'd0;
                for (int k = 0; k < nb; k++) v = (v << 8) | 32'(m_mem[m_addr + k]);
                exp_dout = v;
            end else begin
                for (int k = 0; k < nb; k++)
                    m_mem[m_addr + k] = 8'(m_data >> (8 * (nb - 1 - k)));
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_phase  = 0;
            exp_moc  = 1'b0;
            exp_err  = 1'b0;
            exp_dout = 32'd0;
            exp_dvalid = 1'b0;
        end else begin
            case (m_phase)
                0: if (mov) begin
                    m_rw = rw; m_size = size; m_addr = addr; m_data = data_in;
                    m_wait = LAT;
                    m_phase = 1;
                end
                1: if (!mov) m_phase = 0;
                   else if (m_wait > 0) m_wait--;
                   else begin
                       model_access();
                       exp_moc = 1'b1;
                       m_phase = 2;
                   end
                default: if (!mov) begin
                    exp_moc = 1'b0;
                    exp_err = 1'b0;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_moc", {31'b0, moc}, {31'b0, exp_moc});
            chk("model_err", {31'b0, err}, {31'b0, exp_err});
            if (exp_moc && exp_dvalid) chk("model_dout", data_out, exp_dout);
        end
    end

    task automatic wait_moc(input bit scramble, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (scramble && i == 0) begin
                rw = ~rw; addr = ~addr; data_in = ~data_in; size = ~size;
            end
            if (moc) begin
                lat = i;
                break;
            end
        end
        chk("moc_seen", {31'b0, moc}, 32'd1);
    endtask

    task automatic do_req(input logic r, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] dout, output logic e);
        @(negedge clk);
        mov = 1'b1; rw = r; size = s; addr = a; data_in = d;
        wait_moc(1'b1, lat);
        dout = data_out;
        e    = err;
        mov  = 1'b0;
        @(negedge clk);
        chk("moc_release", {31'b0, moc}, 32'd0);
    endtask

    task automatic xact(input string nm, input logic r, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_e, input logic [31:0] exp_d);
        int lat;
        logic [31:0] dout;
        logic e;
        do_req(r, s, a, d, lat, dout, e);
        chk({nm, "_lat"}, 32'(lat), 32'd3);
        chk({nm, "_err"}, {31'b0, e}, {31'b0, exp_e});
        if (r || exp_e) chk({nm, "_dout"}, dout, exp_d);
    endtask

    initial begin
        int lat;
        reset = 1'b1; mov = 1'b0; rw = 1'b0; size = 2'b00; addr = '0; data_in = '0;
        mov0 = 1'b0; rw0 = 1'b0; size0 = 2'b00; addr0 = '0; data_in0 = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_moc", {31'b0, moc}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_dout", data_out, 32'd0);

        xact("wr_word10", 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
        xact("rd_word10", 1'b1, 2'b10, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
        xact("rd_byte11", 1'b1, 2'b00, 32'h11, 32'd0, 1'b0, 32'h000000AD);
        xact("rd_half12", 1'b1, 2'b01, 32'h12, 32'd0, 1'b0, 32'h0000BEEF);
        xact("wr_byte13", 1'b0, 2'b00, 32'h13, 32'hFFFFFF55, 1'b0, 32'd0);
        xact("rd_merge",  1'b1, 2'b10, 32'h10, 32'd0, 1'b0, 32'hDEADBE55);

        xact("rd_mis02",  1'b1, 2'b10, 32'h02, 32'd0, 1'b1, 32'd0);
        xact("wr_word20", 1'b0, 2'b10, 32'h20, 32'h11223344, 1'b0, 32'd0);
        xact("wr_mis21",  1'b0, 2'b01, 32'h21, 32'h0000AAAA, 1'b1, 32'd0);
        xact("rd_word20", 1'b1, 2'b10, 32'h20, 32'd0, 1'b0, 32'h11223344);
        xact("rd_depth",  1'b1, 2'b00, 32'h100, 32'd0, 1'b1, 32'd0);
        xact("wr_wordFC", 1'b0, 2'b10, 32'hFC, 32'hA5C3E781, 1'b0, 32'd0);
        xact("rd_wordFC", 1'b1, 2'b10, 32'hFC, 32'd0, 1'b0, 32'hA5C3E781);
        xact("rd_byteFF", 1'b1, 2'b00, 32'hFF, 32'd0, 1'b0, 32'h00000081);
        xact("rd_halfFF", 1'b1, 2'b01, 32'hFF, 32'd0, 1'b1, 32'd0);
        xact("rd_hibits", 1'b1, 2'b10, 32'h100000FC, 32'd0, 1'b1, 32'd0);
        xact("rd_size11", 1'b1, 2'b11, 32'h10, 32'd0, 1'b1, 32'd0);

        // Hold mov through ACK, then drop it and re-request as moc falls.
        @(negedge clk);
        mov = 1'b1; rw = 1'b1; size = 2'b10; addr = 32'h10;
        wait_moc(1'b0, lat);
        chk("hold_lat", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_moc", {31'b0, moc}, 32'd1);
            chk("hold_dout", data_out, 32'hDEADBE55);
        end
        mov = 1'b0;
        @(negedge clk);
        chk("drop_moc", {31'b0, moc}, 32'd0);
        chk("drop_dout_kept", data_out, 32'hDEADBE55);
        mov = 1'b1; size = 2'b01; addr = 32'h12;
        wait_moc(1'b0, lat);
        chk("reassert_lat", 32'(lat), 32'd3);
        chk("reassert_dout", data_out, 32'h0000BE55);
        mov = 1'b0;
        @(negedge clk);

        // Abort a write during BUSY.
        xact("wr_word30", 1'b0, 2'b10, 32'h30, 32'h01020304, 1'b0, 32'd0);
        @(negedge clk);
        mov = 1'b1; rw = 1'b0; size = 2'b10; addr = 32'h30; data_in = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        mov = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_moc", {31'b0, moc}, 32'd0);
        end
        xact("rd_abort30", 1'b1, 2'b10, 32'h30, 32'd0, 1'b0, 32'h01020304);

        // Reset while in ACK.
        @(negedge clk);
        mov = 1'b1; rw = 1'b1; size = 2'b10; addr = 32'h20;
        wait_moc(1'b0, lat);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ack_moc", {31'b0, moc}, 32'd0);
        chk("rst_ack_dout", data_out, 32'd0);
        reset = 1'b0; mov = 1'b0;
        @(negedge clk);
        xact("after_rst", 1'b1, 2'b00, 32'h23, 32'd0, 1'b0, 32'h00000044);

        // Reset and mov together: request must not be latched at the reset edge.
        @(negedge clk);
        reset = 1'b1; mov = 1'b1; rw = 1'b1; size = 2'b10; addr = 32'h10;
        @(negedge clk);
        reset = 1'b0;
        wait_moc(1'b0, lat);
        chk("rst_mov_lat", 32'(lat), 32'd3);
        chk("rst_mov_dout", data_out, 32'hDEADBE55);
        mov = 1'b0;
        @(negedge clk);

        // LATENCY=0 instance: moc after the second edge from the sampling edge.
        mov0 = 1'b1; rw0 = 1'b0; size0 = 2'b10; addr0 = 32'h40; data_in0 = 32'h12345678;
        @(negedge clk);
        chk("l0_wr_busy", {31'b0, moc0}, 32'd0);
        @(negedge clk);
        chk("l0_wr_moc", {31'b0, moc0}, 32'd1);
        chk("l0_wr_err", {31'b0, err0}, 32'd0);
        mov0 = 1'b0;
        @(negedge clk);
        chk("l0_wr_rel", {31'b0, moc0}, 32'd0);
        mov0 = 1'b1; rw0 = 1'b1;
        @(negedge clk);
        chk("l0_rd_busy", {31'b0, moc0}, 32'd0);
        @(negedge clk);
        chk("l0_rd_moc", {31'b0, moc0}, 32'd1);
        chk("l0_rd_dout", data_out0, 32'h12345678);
        mov0 = 1'b0;
        @(negedge clk);
        chk("l0_rd_rel", {31'b0, moc0}, 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_moc_responder.md
Name: mem_moc_responder

Overview:
- Memory-side responder for the control unit's MOV/MOC handshake.
- The control unit asserts `mov` with address, direction and size, then holds until `moc` returns. In state 3 it waits on `moc` before advancing.
- This block models a byte-addressed, big-endian RAM with a programmable wait-state latency.
- It performs byte, halfword and word reads and writes, and signals completion (and errors) through `moc`/`err`.

Parameters:
- DEPTH, 256, memory size in bytes (power of two, ≥4)
- LATENCY, 2, wait states between sampling `mov` and the access commit (0..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- mov  input  1  memory operation valid, from the control unit
- rw  input  1  1 = read, 0 = write
- size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (error)
- addr  input  32  byte address
- data_in  input  32  write data; byte in [7:0], halfword in [15:0]
- data_out  output  32  read data, zero-extended; valid while `moc`=1
- moc  output  1  memory operation complete
- err  output  1  access fault; valid while `moc`=1

Behaviour:
- Reset values:
  - `moc`=0, `err`=0, `data_out`=0, state=IDLE, counter=0.
  - Memory array is NOT cleared by reset.
- State machine states: IDLE, BUSY, ACK. State encoding is free.
- IDLE:
  - `mov`=1 sampled at edge N: latch `addr`, `rw`, `size`, `data_in`; load counter=LATENCY; go to BUSY.
  - Inputs are ignored after the latch.
- BUSY:
  - `mov`=0: abort, go to IDLE. No write, `moc` stays 0.
  - Else if counter≠0: decrement.
  - Else: commit the access, set `moc`=1, register `data_out`/`err`, go to ACK.
- Latency: `moc` rises after edge N+1+LATENCY (LATENCY=2 → three cycles after `mov` is first sampled).
- ACK:
  - Hold `moc`, `data_out` and `err` stable while `mov`=1.
  - On `mov`=0: next edge sets `moc`=0, `err`=0, returns to IDLE. `data_out` retains its value.
  - A new request needs at least one IDLE cycle. Back-to-back minimum period is LATENCY+3 cycles.
- Error conditions, checked at commit on latched values:
  - size=11
  - halfword with addr[0]=1
  - word with addr[1:0]≠00
  - addr+bytes > DEPTH (out of range)
- On error: `err`=1 and `moc`=1 (normal completion timing), no memory write, `data_out`=0.
- Byte ordering is big-endian:
  - Word at A: mem[A]→[31:24], mem[A+1]→[23:16], mem[A+2]→[15:8], mem[A+3]→[7:0].
  - Halfword at A: mem[A]→[15:8], mem[A+1]→[7:0].
  - Byte: →[7:0].
  - Upper bits are zero. Sign extension belongs to the datapath.
- Writes store only the addressed bytes, from the low bits of latched `data_in`, using the same mapping. Other bytes are unchanged.
- Reset during BUSY or ACK: request abandoned, no write committed, `moc`=0 the cycle after reset.
- Reset and `mov`=1 in the same cycle: reset wins; the request is not latched.
- Address bits above log2(DEPTH) participate only in the range check.
- Write data is committed exactly once per accepted request.

Test Plan:
- Word write then read, LATENCY=2:
  - Write 0xDEADBEEF to addr 0x10 → `moc` high 3 cycles after `mov`, `err`=0.
  - Read word 0x10 → `data_out`=0xDEADBEEF.
  - Read byte 0x11 → 0x000000AD.
  - Read halfword 0x12 → 0x0000BEEF.
- Byte write merge:
  - Write byte 0x55 (`data_in`=0xFFFFFF55) to 0x13 after the word above.
  - Read word 0x10 → 0xDEADBE55.
- Misaligned and out-of-range:
  - Word read at 0x02 → `moc`=1, `err`=1, `data_out`=0.
  - Halfword write 0xAAAA at 0x21 → `err`=1, and word 0x20 is unchanged.
  - Byte read at DEPTH → `err`=1.
- Handshake hold and release:
  - Keep `mov`=1 for 5 cycles after `moc` → `moc`/`data_out` stable.
  - Drop `mov` → `moc`=0 next edge.
  - Re-assert `mov` the same cycle `moc` falls → not accepted until IDLE is sampled.
- Abort cases:
  - Drop `mov` during BUSY of a write to 0x30 → no `moc`; a later read of 0x30 returns the prior contents.
  - Assert `reset` in ACK → `moc`=0 next cycle, FSM in IDLE.
- LATENCY=0 build: read request → `moc` high after the second edge following `mov` sample.
